// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sequencer.
// Pure declarations; no latency.
// No flow control of its own.
package parking_pkg;

  localparam int SLOT_W   = 3;
  localparam int N_SLOTS  = 8;
  localparam int FEE_RATE = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    RESP  = 2'd3
  } gate_state_t;

  // Number of taken slots; fits in 4 bits for 8 slots.
  function automatic logic [3:0] popcount_occ(input logic [N_SLOTS-1:0] occ);
    logic [3:0] sum;
    sum = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      sum = sum + 4'(occ[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/parking_gate_sequencer_slot_alloc.sv
// Lowest-free-slot priority encoder over the occupancy register.
// Latency: purely combinational.
// Backpressure: none; none_free tells the caller the lot is full.
module slot_alloc
  import parking_pkg::*;
(
  input  logic [N_SLOTS-1:0] occupancy,
  output slot_t              free_slot,
  output logic               none_free
);

  // Scan from the top down so the lowest clear bit is the last one to win.
  always_comb begin
    free_slot = '0;
    none_free = 1'b1;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_slot = slot_t'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_gate_sequencer.sv
// Gate controller: serialises entry/exit requests, owns occupancy and stay timestamps.
// Latency: response pulse 2 cycles after the accept edge; one request per 3 cycles.
// Backpressure: req_ready is high only in IDLE; requests are levels held until accepted.
// Optional build macro PARK_FEE_EN adds a registered, saturated fee output.
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              entry_req,
  input  logic              exit_req,
  input  logic [2:0]        exit_token,
  input  logic [2:0]        pattern,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_ok,
  output logic [2:0]        token,
  output logic [TIME_W-1:0] time_total,
  output logic [7:0]        occupancy,
  output logic [3:0]        parked,
  output logic [3:0]        empty,
  output logic              full
`ifdef PARK_FEE_EN
  ,
  output logic [7:0]        fee
`endif
);

  gate_state_t       state_q, state_d;
  slot_t             pat_q, pat_d;
  slot_t             xtok_q, xtok_d;
  logic [N_SLOTS-1:0] occ_q, occ_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] ts_q [N_SLOTS];
  logic [TIME_W-1:0] ts_d [N_SLOTS];
  slot_t             token_q, token_d;
  logic [TIME_W-1:0] total_q, total_d;
  logic              ok_q, ok_d;
`ifdef PARK_FEE_EN
  logic [7:0]        fee_q, fee_d;
  logic [TIME_W+1:0] fee_prod;
`endif

  slot_t free_slot;
  logic  none_free;
  slot_t exit_slot;

  slot_alloc u_slot_alloc (
    .occupancy (occ_q),
    .free_slot (free_slot),
    .none_free (none_free)
  );

  // The exit token is descrambled with the pattern captured at accept time.
  assign exit_slot = xtok_q ^ pat_q;

  // Next-state, occupancy/timestamp updates and response registers.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    xtok_d  = xtok_q;
    occ_d   = occ_q;
    ts_d    = ts_q;
    token_d = token_q;
    total_d = total_q;
    ok_d    = ok_q;
`ifdef PARK_FEE_EN
    fee_d    = fee_q;
    fee_prod = '0;
`endif
    // Time base runs in every state; ENTRY below stores the pre-increment value.
    time_d = tick ? time_q + 1'b1 : time_q;

    unique case (state_q)
      IDLE: begin
        // Exit has priority; a coincident entry stays asserted and is taken next IDLE.
        if (exit_req || entry_req) begin
          pat_d   = pattern;
          xtok_d  = exit_token;
          state_d = exit_req ? EXIT : ENTRY;
        end
      end
      ENTRY: begin
        if (!none_free) begin
          occ_d[free_slot] = 1'b1;
          ts_d[free_slot]  = time_q;
          token_d          = free_slot ^ pat_q;
          ok_d             = 1'b1;
        end else begin
          token_d = '0;
          ok_d    = 1'b0;
        end
`ifdef PARK_FEE_EN
        fee_d = '0;
`endif
        state_d = RESP;
      end
      EXIT: begin
        if (occ_q[exit_slot]) begin
          occ_d[exit_slot] = 1'b0;
          // Modular subtraction: stays longer than the time base alias.
          total_d = time_q - ts_q[exit_slot];
          ok_d    = 1'b1;
`ifdef PARK_FEE_EN
          fee_prod = (TIME_W+2)'(total_d) * (TIME_W+2)'(FEE_RATE);
          fee_d    = (fee_prod > (TIME_W+2)'(8'hFF)) ? 8'hFF : fee_prod[7:0];
`endif
        end else begin
          total_d = '0;
          ok_d    = 1'b0;
`ifdef PARK_FEE_EN
          fee_d = '0;
`endif
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      xtok_q  <= '0;
      occ_q   <= '0;
      time_q  <= '0;
      token_q <= '0;
      total_q <= '0;
      ok_q    <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        ts_q[i] <= '0;
      end
`ifdef PARK_FEE_EN
      fee_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      xtok_q  <= xtok_d;
      occ_q   <= occ_d;
      time_q  <= time_d;
      token_q <= token_d;
      total_q <= total_d;
      ok_q    <= ok_d;
      for (int i = 0; i < N_SLOTS; i++) begin
        ts_q[i] <= ts_d[i];
      end
`ifdef PARK_FEE_EN
      fee_q <= fee_d;
`endif
    end
  end

  // Status outputs decode straight from the registers.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_ok    = ok_q;
  assign token      = token_q;
  assign time_total = total_q;
  assign occupancy  = occ_q;
  assign parked     = popcount_occ(occ_q);
  assign empty      = 4'(N_SLOTS) - parked;
  assign full       = &occ_q;
`ifdef PARK_FEE_EN
  assign fee        = fee_q;
`endif

endmodule

// File: tb/tb_parking_gate_sequencer.sv
module tb_parking_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_token = '0;
  logic [2:0] pattern = '0;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_ok;
  logic [2:0] token;
  logic [7:0] time_total;
  logic [7:0] occupancy;
  logic [3:0] parked;
  logic [3:0] empty;
  logic       full;
`ifdef PARK_FEE_EN
  logic [7:0] fee;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parking_gate_sequencer #(.TIME_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .exit_token (exit_token),
    .pattern    (pattern),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ok    (resp_ok),
    .token      (token),
    .time_total (time_total),
    .occupancy  (occupancy),
    .parked     (parked),
    .empty      (empty),
    .full       (full)
`ifdef PARK_FEE_EN
    ,
    .fee        (fee)
`endif
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge clk);
    entry_req = 0; exit_req = 0; tick = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic ticks(input int n);
    @(negedge clk);
    tick = 1;
    repeat (n) @(posedge clk);
    #1 tick = 0;
  endtask

  // Present a request for exactly one accept edge; returns 1 ns after it.
  task automatic issue(input logic e, input logic x, input logic [2:0] tok, input logic [2:0] pat);
    @(negedge clk);
    entry_req = e; exit_req = x; exit_token = tok; pattern = pat;
    @(posedge clk);
    #1 entry_req = 0; exit_req = 0;
  endtask

  // Count falling edges after the accept edge until resp_valid; 0 if it never comes.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    n_cmp++; if (occupancy !== 8'h00) begin n_fail++; $display("FAIL reset_occ: got %h want 00", occupancy); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", resp_ok); end
    n_cmp++; if (token !== 3'd0) begin n_fail++; $display("FAIL reset_token: got %0d want 0", token); end
    n_cmp++; if (time_total !== 8'd0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", time_total); end
    n_cmp++; if (parked !== 4'd0) begin n_fail++; $display("FAIL reset_parked: got %0d want 0", parked); end
    n_cmp++; if (empty !== 4'd8) begin n_fail++; $display("FAIL reset_empty: got %0d want 8", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
`ifdef PARK_FEE_EN
    n_cmp++; if (fee !== 8'd0) begin n_fail++; $display("FAIL reset_fee: got %0d want 0", fee); end
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_entry();
    int lat;
    do_reset();
    issue(1, 0, 3'd0, 3'b101);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL entry_busy: ready got %b want 0", req_ready); end
    wait_resp(lat);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL entry_latency: got %0d want 2", lat); end
    n_cmp++; if (resp_ok !== 1'b1) begin n_fail++; $display("FAIL entry_ok: got %b want 1", resp_ok); end
    n_cmp++; if (token !== 3'b101) begin n_fail++; $display("FAIL entry_token: got %b want 101", token); end
    n_cmp++; if (occupancy !== 8'h01) begin n_fail++; $display("FAIL entry_occ: got %h want 01", occupancy); end
    n_cmp++; if (parked !== 4'd1) begin n_fail++; $display("FAIL entry_parked: got %0d want 1", parked); end
    n_cmp++; if (empty !== 4'd7) begin n_fail++; $display("FAIL entry_empty: got %0d want 7", empty); end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL entry_pulse: got %b want 0", resp_valid); end
    n_cmp++; if (token !== 3'b101) begin n_fail++; $display("FAIL entry_hold: got %b want 101", token); end
  endtask

  task automatic test_full();
    int lat;
    for (int s = 1; s < 8; s++) begin
      issue(1, 0, 3'd0, 3'd0);
      wait_resp(lat);
      n_cmp++; if (lat != 2 || resp_ok !== 1'b1 || token !== 3'(s))
        begin n_fail++; $display("FAIL fill_slot%0d: lat %0d ok %b token %0d want lat 2 ok 1 token %0d", s, lat, resp_ok, token, s); end
    end
    n_cmp++; if (occupancy !== 8'hFF) begin n_fail++; $display("FAIL fill_occ: got %h want ff", occupancy); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (empty !== 4'd0) begin n_fail++; $display("FAIL fill_empty: got %0d want 0", empty); end
    issue(1, 0, 3'd0, 3'b011);
    wait_resp(lat);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL full_latency: got %0d want 2", lat); end
    n_cmp++; if (resp_ok !== 1'b0) begin n_fail++; $display("FAIL full_ok: got %b want 0", resp_ok); end
    n_cmp++; if (token !== 3'd0) begin n_fail++; $display("FAIL full_token: got %0d want 0", token); end
    n_cmp++; if (occupancy !== 8'hFF) begin n_fail++; $display("FAIL full_occ: got %h want ff", occupancy); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
  endtask

  task automatic test_exit_time();
    int lat;
    do_reset();
    ticks(10);
    issue(1, 0, 3'd0, 3'd0);
    wait_resp(lat);
    ticks(25);
    issue(0, 1, 3'd0, 3'd0);
    wait_resp(lat);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL exit_latency: got %0d want 2", lat); end
    n_cmp++; if (resp_ok !== 1'b1) begin n_fail++; $display("FAIL exit_ok: got %b want 1", resp_ok); end
    n_cmp++; if (time_total !== 8'd25) begin n_fail++; $display("FAIL exit_total: got %0d want 25", time_total); end
    n_cmp++; if (occupancy !== 8'h00) begin n_fail++; $display("FAIL exit_occ: got %h want 00", occupancy); end
`ifdef PARK_FEE_EN
    n_cmp++; if (fee !== 8'd50) begin n_fail++; $display("FAIL exit_fee: got %0d want 50", fee); end
`endif
  endtask

  task automatic test_exit_reject();
    int lat;
    issue(1, 0, 3'd0, 3'd0);
    wait_resp(lat);
    issue(0, 1, 3'd3, 3'd0);
    wait_resp(lat);
    n_cmp++; if (resp_ok !== 1'b0) begin n_fail++; $display("FAIL reject_ok: got %b want 0", resp_ok); end
    n_cmp++; if (time_total !== 8'd0) begin n_fail++; $display("FAIL reject_total: got %0d want 0", time_total); end
    n_cmp++; if (occupancy !== 8'h01) begin n_fail++; $display("FAIL reject_occ: got %h want 01", occupancy); end
`ifdef PARK_FEE_EN
    n_cmp++; if (fee !== 8'd0) begin n_fail++; $display("FAIL reject_fee: got %0d want 0", fee); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    bit seen_idle;
    // slot 0 is occupied; token 2 with pattern 2 decodes to slot 0
    @(negedge clk);
    entry_req = 1; exit_req = 1; exit_token = 3'd2; pattern = 3'd2;
    @(posedge clk);
    #1 exit_req = 0;
    wait_resp(lat);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL b2b_exit_latency: got %0d want 2", lat); end
    n_cmp++; if (resp_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_exit_ok: got %b want 1", resp_ok); end
    n_cmp++; if (occupancy !== 8'h00) begin n_fail++; $display("FAIL b2b_exit_first: occ got %h want 00", occupancy); end
    gap = 0;
    seen_idle = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!req_ready && seen_idle) entry_req = 0;
      if (req_ready) seen_idle = 1;
      if (resp_valid) begin
        gap = k;
        break;
      end
    end
    entry_req = 0;
    n_cmp++; if (gap != 3) begin n_fail++; $display("FAIL b2b_gap: got %0d want 3", gap); end
    n_cmp++; if (resp_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_entry_ok: got %b want 1", resp_ok); end
    n_cmp++; if (token !== 3'd2) begin n_fail++; $display("FAIL b2b_entry_token: got %0d want 2", token); end
    n_cmp++; if (occupancy !== 8'h01) begin n_fail++; $display("FAIL b2b_entry_occ: got %h want 01", occupancy); end
  endtask

  task automatic test_wrap();
    int lat;
    do_reset();
    ticks(250);
    issue(1, 0, 3'd0, 3'd0);
    wait_resp(lat);
    ticks(10);
    issue(0, 1, 3'd0, 3'd0);
    wait_resp(lat);
    n_cmp++; if (resp_ok !== 1'b1) begin n_fail++; $display("FAIL wrap_ok: got %b want 1", resp_ok); end
    n_cmp++; if (time_total !== 8'd10) begin n_fail++; $display("FAIL wrap_total: got %0d want 10", time_total); end
`ifdef PARK_FEE_EN
    n_cmp++; if (fee !== 8'd20) begin n_fail++; $display("FAIL wrap_fee: got %0d want 20", fee); end
`endif
  endtask

  task automatic test_reset_abort();
    int seen;
    do_reset();
    issue(1, 0, 3'd0, 3'd0);
    rst_n = 0;
    #3 rst_n = 1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL abort_resp: got %0d pulses want 0", seen); end
    n_cmp++; if (occupancy !== 8'h00) begin n_fail++; $display("FAIL abort_occ: got %h want 00", occupancy); end
    n_cmp++; if (parked !== 4'd0) begin n_fail++; $display("FAIL abort_parked: got %0d want 0", parked); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full();
    test_exit_time();
    test_exit_reject();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
